// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter with lock for a shared single-port synchronous memory
// Grants one requester per cycle, drives the memory, and strobes the response back one cycle later.
module mem_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ-1:0]               req_lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [ADDR_WIDTH-1:0]            mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_wdata,
    output logic                             mem_rw,
    input  logic [DATA_WIDTH-1:0]            mem_rdata
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDW-1:0] id_t;

    typedef enum logic {
        LK_FREE = 1'b0,
        LK_HELD = 1'b1
    } lock_state_t;

    lock_state_t lock_state;
    lock_state_t lock_next;
    id_t         lock_owner;
    id_t         owner_next;
    id_t         rr_ptr;
    id_t         rr_next;
    logic        rsp_pending;
    id_t         rsp_id;

    logic        grant_found;
    logic        grant_held;
    id_t         grant_id;
    id_t         cand_id;
    logic        transfer;

    // Held lock wins while its owner keeps asking; otherwise search from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_held  = 1'b0;
        grant_id    = '0;
        cand_id     = '0;
        if (lock_state == LK_HELD && req_valid[lock_owner]) begin
            grant_found = 1'b1;
            grant_held  = 1'b1;
            grant_id    = lock_owner;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand_id = id_t'((int'(rr_ptr) + k) % NUM_REQ);
                if (!grant_found && req_valid[cand_id]) begin
                    grant_found = 1'b1;
                    grant_id    = cand_id;
                end
            end
        end
    end

    // Reset gates the grant combinationally so the memory sees an idle read at once.
    assign transfer = grant_found & reset;
    assign rr_next  = id_t'((int'(grant_id) + 1) % NUM_REQ);

    always_comb begin
        req_ready = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
            mem_addr            = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata           = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            mem_rw              = req_rw[grant_id];
        end
    end

    // With no transfer the owner cannot be valid, so the lock is dropped.
    always_comb begin
        lock_next  = lock_state;
        owner_next = lock_owner;
        if (transfer) begin
            if (req_lock[grant_id]) begin
                lock_next  = LK_HELD;
                owner_next = grant_id;
            end else begin
                lock_next = LK_FREE;
            end
        end else begin
            lock_next = LK_FREE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_state  <= LK_FREE;
            lock_owner  <= '0;
            rr_ptr      <= '0;
            rsp_pending <= 1'b0;
            rsp_id      <= '0;
        end else begin
            lock_state  <= lock_next;
            lock_owner  <= owner_next;
            if (transfer && !grant_held) begin
                rr_ptr <= rr_next;
            end
            rsp_pending <= transfer;
            rsp_id      <= grant_id;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (rsp_pending) begin
            rsp_valid[rsp_id] = 1'b1;
        end
    end

    assign rsp_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural arbitration/memory model
// Directed scenarios followed by randomized traffic; a monitor pops expected responses as they appear.
module tb_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_rw;
    logic [N-1:0]      req_lock;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rw;
    logic [DW-1:0]     mem_rdata;

    mem_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Read-first synchronous memory driven by the arbiter.
    logic [DW-1:0] mem [0:63];
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr[5:0]];
        if (mem_rw) mem[mem_addr[5:0]] <= mem_wdata;
    end

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    rsp_t        sb[$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] ref_mem [0:63];
    int          m_rr = 0;
    int          m_owner = 0;
    bit          m_locked = 1'b0;

    logic [5:0]  t_addr  [N];
    logic [31:0] t_wdata [N];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic bit bit_at(input logic [N-1:0] v, input int idx);
        logic [N-1:0] t;
        t = v >> idx;
        return t[0];
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        if (m_locked && bit_at(v, m_owner)) return m_owner;
        for (int k = 0; k < N; k++) begin
            if (bit_at(v, (m_rr + k) % N)) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] rw, input logic [N-1:0] lk);
        int           g;
        bit           held;
        logic [N-1:0] er;
        @(posedge clk);
        #1;
        req_valid = v;
        req_rw    = rw;
        req_lock  = lk;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = {26'b0, t_addr[i]};
            req_wdata[i*DW +: DW] = t_wdata[i];
        end
        @(negedge clk);
        held = m_locked && bit_at(v, m_owner);
        g    = model_grant(v);
        er   = '0;
        if (g >= 0) er = N'(1) << g;
        check("req_ready", 32'(req_ready), 32'(er));
        if (g >= 0) begin
            check("mem_addr", mem_addr, {26'b0, t_addr[g]});
            check("mem_rw", 32'(mem_rw), 32'(bit_at(rw, g)));
            if (bit_at(rw, g)) check("mem_wdata", mem_wdata, t_wdata[g]);
            sb.push_back('{g, ref_mem[t_addr[g]], cycle});
            if (bit_at(rw, g)) ref_mem[t_addr[g]] = t_wdata[g];
            if (!held) m_rr = (g + 1) % N;
            m_locked = bit_at(lk, g);
            m_owner  = g;
        end else begin
            check("mem_rw_idle", 32'(mem_rw), 32'd0);
            m_locked = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (reset) begin
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'(N'(1) << e.id));
                    check("rsp_rdata", rsp_rdata, e.data);
                    check("rsp_latency", 32'(cycle), 32'(e.cyc + 1));
                end
            end else if (sb.size() > 0 && sb[0].cyc + 1 == cycle) begin
                e = sb.pop_front();
                check("rsp_missing", 32'(rsp_valid), 32'(N'(1) << e.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] saved;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        reset     = 1'b0;
        req_valid = '1;
        req_rw    = '1;
        req_lock  = '0;
        req_addr  = '1;
        req_wdata = '1;
        #3;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mem_rw", 32'(mem_rw), 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_mem_wdata", mem_wdata, 32'd0);
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        t_addr[0] = 6'h10;
        step(3'b001, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        t_addr[1] = 6'h20; t_wdata[1] = 32'h5A5A0001;
        step(3'b010, 3'b010, 3'b000);
        step(3'b010, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        t_addr[0] = 6'h01; t_addr[1] = 6'h02;
        repeat (6) step(3'b011, 3'b000, 3'b000);

        t_addr[0] = 6'h03; t_wdata[0] = 32'h0000CAFE;
        repeat (3) step(3'b011, 3'b000, 3'b001);
        step(3'b011, 3'b001, 3'b000);
        step(3'b011, 3'b000, 3'b000);

        step(3'b011, 3'b000, 3'b001);
        step(3'b010, 3'b000, 3'b000);
        step(3'b011, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                t_addr[i]  = 6'($urandom_range(0, 63));
                t_wdata[i] = $urandom;
            end
            step(N'($urandom), N'($urandom), ($urandom_range(0, 2) == 0) ? N'($urandom) : '0);
        end
        step(3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);

        t_addr[0] = 6'h05; t_addr[1] = 6'h06; t_addr[2] = 6'h07;
        t_wdata[0] = 32'h12345678;
        step(3'b010, 3'b000, 3'b000);
        saved = ref_mem[6'h05];
        step(3'b001, 3'b001, 3'b000);
        #1;
        reset = 1'b0;
        #1;
        check("async_req_ready", 32'(req_ready), 32'd0);
        check("async_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_mem_rw", 32'(mem_rw), 32'd0);
        sb.delete();
        ref_mem[6'h05] = saved;
        m_rr = 0; m_locked = 1'b0; m_owner = 0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step(3'b111, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b000);
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Round-robin arbiter that shares the single-port synchronous memory between NUM_REQ requesters (port 0 = core load/store, port 1 = quantum pulse sequencer, others spare). It owns the memory's addr/wdata/mem_rw inputs and returns the registered read data to the granted requester one cycle later. It also provides a lock so one requester can issue back-to-back read-modify-write sequences without interleaving.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 32, request/memory address width
DATA_WIDTH, 32, write/read data width; matches MEM_DATA_WIDTH and the memory's 32-bit rdata

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset; clears all arbiter state
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
req_rw  input  NUM_REQ  1 = write, 0 = read
req_lock  input  NUM_REQ  hold the grant for the following request of the same requester
req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; slice i is [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  flattened write data
rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle after the grant
rsp_rdata  output  DATA_WIDTH  shared response data, valid while any rsp_valid bit is high
mem_addr  output  ADDR_WIDTH  to memory addr
mem_wdata  output  DATA_WIDTH  to memory wdata
mem_rw  output  1  to memory mem_rw
mem_rdata  input  DATA_WIDTH  from memory rdata

Behaviour:
- Reset (reset=0, asynchronous): rr_ptr=0, locked=0, lock_owner=0, rsp_pending=0, rsp_id=0. Outputs: req_ready=0, rsp_valid=0, mem_rw=0, mem_addr=0, mem_wdata=0, rsp_rdata=mem_rdata passthrough (don't-care while rsp_valid=0).
- Grant (combinational, same cycle):
  - If locked and req_valid[lock_owner]=1, grant lock_owner.
  - Else, if any req_valid bit is set, grant the first valid index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Else, no grant.
- Any cycle: at most one req_ready bit high. req_ready is never high without the matching req_valid.
- Memory drive (combinational): on grant g, mem_addr/mem_wdata come from slice g and mem_rw=req_rw[g]. With no grant, mem_rw=0, mem_addr=0, mem_wdata=0; the idle read is harmless.
- Memory timing: the memory samples on the posedge and presents rdata after that edge. It is read-first, so a write returns the old contents.
- Response latency: exactly 1 cycle.
  - A transfer in cycle N gives rsp_valid[g]=1 in cycle N+1, with rsp_rdata=mem_rdata.
  - Writes also get rsp_valid as an acknowledge; rsp_rdata then holds the pre-write data.
  - No back-pressure on responses: requesters must accept them.
- Throughput: one transfer per cycle. Back-to-back grants are allowed, and a grant in cycle N+1 overlaps the response for cycle N.
- rr_ptr update: after any transfer by g, rr_ptr <= (g+1) mod NUM_REQ. It is unchanged when there is no transfer or when the grant came from a held lock.
- Lock:
  - A transfer by g with req_lock[g]=1 sets locked=1 and lock_owner=g.
  - A transfer with req_lock[g]=0 clears locked.
  - If locked and req_valid[lock_owner]=0, the lock is dropped that cycle (locked <= 0) and normal round-robin grant applies in the same cycle, so a lock never stalls the memory.
- Simultaneous events: a new transfer in the same cycle a response is returned is legal. rsp_pending and rsp_id are overwritten each cycle from the current transfer (pending=1 if there is a transfer, else 0).
- Reset mid-operation: an outstanding response is dropped (rsp_valid=0 after reset). Any write already sampled by the memory stays committed.
- NUM_REQ=1 degenerates to a pass-through with a 1-cycle response strobe.

Test Plan:
1. Read: mem[0x10]=0xDEADBEEF preloaded; req0 read addr 0x10 in cycle N. Expect req_ready=01 in N and rsp_valid=01 with rsp_rdata=0xDEADBEEF in N+1.
2. Write then read: req1 writes 0x5A5A0001 to 0x20, then reads 0x20 on the next cycle. Expect the write-ack rdata to be the old value, then 0x5A5A0001; 2 transfers in 2 cycles.
3. Contention: both requesters hold valid for 6 cycles starting with rr_ptr=0. Expect grants 0,1,0,1,0,1 and rsp_valid to follow one cycle later with the matching ids.
4. Lock: req0 issues 3 locked reads followed by an unlocked write while req1 stays valid. Expect four consecutive req0 grants, then req1 granted on the next cycle.
5. Lock drop: req0 locks, then deasserts valid while req1 is valid. Expect req1 granted in that same cycle and locked=0.
6. Async reset: assert reset low mid-cycle right after a grant. Expect req_ready, rsp_valid and mem_rw to go to 0 immediately and no response after release; the first grant after release goes to port 0.
